uart_rx: RTL
============

Name: uart_rx

Overview:
- Memory-mapped UART receiver; the receive counterpart of the SoC's uart transmitter. Shares the same CLK_MHZ/baud derivation.
- Deserialises 8N1 frames from the `rx` pin and buffers received bytes in a small FIFO.
- Exposes the FIFO head, sticky error flags and an occupancy count so the SoC memory decoder can serve reads at address-high 4'h3.

Parameters:
- CLK_MHZ, 12, system clock frequency in MHz.
- BAUD, 115200, line rate in bit/s. DIV = (CLK_MHZ*1000000 + BAUD/2) / BAUD, i.e. 104 at the defaults.
- FIFO_DEPTH, 8, number of buffered bytes; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- rx  in  1  serial input, idles high, asynchronous to clk.
- rd_data  out  8  FIFO head byte; 8'h00 when the FIFO is empty.
- rd_valid  out  1  FIFO is non-empty.
- rd_ready  in  1  pop strobe; a byte is popped when rd_valid && rd_ready.
- count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- clr_err  in  1  single-cycle pulse that clears frame_err and overrun.

Behaviour:
- Reset values (asynchronous, while resetn=0): both synchroniser flops =1; state=IDLE; bit and baud counters=0; FIFO pointers=0; rd_valid=0, rd_data=0, count=0, frame_err=0, overrun=0.
- A reset asserted mid-frame discards the partial byte with no flag; the FIFO contents are lost.
- Synchroniser: rx passes through 2 flops to give rx_s. Start-edge detection uses rx_s and its 1-cycle delayed copy.
- FSM states:
  - IDLE: a falling edge on rx_s loads the baud counter with DIV/2-1 and moves to START.
  - START: when the counter reaches 0, sample rx_s. Sample 1 means a glitch: return to IDLE. Sample 0 reloads DIV-1, sets bit index 0 and moves to DATA.
  - DATA: each counter expiry shifts rx_s into the shift register, LSB first, and reloads DIV-1. After bit 7, move to STOP.
  - STOP: on counter expiry, sample rx_s.
    - Sample 1: push the byte and go to IDLE.
    - Sample 0: set frame_err, discard the byte and go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Latency: the byte becomes visible on rd_valid/rd_data 1 cycle after the stop-bit sample. That is about 9.5*DIV + 3 cycles after the start edge on rx.
- FIFO rules:
  - The head is registered, so rd_data is stable while rd_valid=1.
  - Pop when empty: ignored.
  - Push when full with no pop: the byte is dropped, overrun is set, contents are unchanged.
  - Push and pop in the same cycle when full: both succeed and count stays at FIFO_DEPTH.
  - Push and pop in the same cycle otherwise: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Error flags: clr_err clears both flags. If an error event occurs in the same cycle as clr_err, the flag ends set (the event wins).
- SoC integration (decoder owned by the soc, listed here for reference):
  - Read 4'h3 word 0 returns {23'b0, rd_valid, rd_data} and pulses rd_ready.
  - Read word 1 returns {count, frame_err, overrun}.
  - Write word 1 pulses clr_err.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - The frame is 8E1. A PARITY state sits between DATA and STOP and samples one extra bit.
  - Parity mismatch sets a sticky parity_err output, cleared by clr_err, and the byte is discarded.
  - The stop bit is still checked.
- When undefined:
  - The frame is 8N1, there is no PARITY state, and the parity_err port is absent.

Decomposition:
- Shared header uart_defs.vh (also included by uart.v) holds:
  - the DIV computation macro;
  - the state encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5.
- One sub-module, sync_fifo: parameterised width and depth, push/pop/full/empty/count, registered head. Kept generic for reuse by a later TX FIFO.

Test Plan (all at CLK_MHZ=12, BAUD=115200, DIV=104):
- Single frame 8'hA5 driven at 104 cycles/bit -> rd_valid rises about 991 cycles after the start edge; rd_data=8'hA5; count=1; no flags.
- 0.5-bit (52-cycle) low glitch on rx -> FSM returns to IDLE; rd_valid stays 0; frame_err=0.
- Frame 8'h3C with stop bit held low, then line low for 2000 cycles -> frame_err=1; nothing pushed; no further frames decoded until rx returns high; clr_err then clears frame_err to 0.
- 9 back-to-back frames 8'h01..8'h09 with rd_ready=0 (FIFO_DEPTH=8) -> count=8, overrun=1; pops return 01..08 in order; 09 is lost.
- With FIFO full, the 9th push lands in the same cycle as a pop -> count stays 8, overrun=0, 8'h09 is present at the tail.
- Assert resetn=0 mid-DATA of frame 8'hFF, release, then send 8'h42 -> only 8'h42 is received; all outputs were at reset values during reset.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART receiver definitions.
//   rx_state_t : receiver FSM encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, BREAK=5)
//   baud_div   : clock cycles per bit, rounded to nearest
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    function automatic int baud_div(input int clk_mhz, input int baud);
        return (clk_mhz * 1000000 + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: generic single-clock FIFO with a registered head word.
//   clk, resetn : clock, asynchronous active-low reset
//   push, din   : write strobe and data; a push when full is dropped unless a pop happens in the same cycle
//   pop         : read strobe; ignored when empty
//   dout        : registered head word, zero when empty
//   full, empty : status flags
//   count       : current occupancy (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr, rd_next;
    logic [AW:0]      cnt_next, kept;
    logic [WIDTH-1:0] head_next;
    logic             do_push, do_pop;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;

    always_comb begin
        do_push  = push & (~full | pop);
        do_pop   = pop & ~empty;
        rd_next  = rd_ptr + AW'(do_pop);
        kept     = count - (AW+1)'(do_pop);
        cnt_next = kept + (AW+1)'(do_push);
        // When nothing survives the pop, the new head (if any) is the word being pushed now.
        head_next = cnt_next == '0 ? '0 : kept == '0 ? din : mem[rd_next];
    end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_next;
            count  <= cnt_next;
            dout   <= head_next;
        end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: memory-mapped UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a receive FIFO.
//   clk, resetn : clock, asynchronous active-low reset
//   rx          : serial input, idles high, asynchronous to clk
//   rd_data     : FIFO head byte (0 when empty); rd_valid: FIFO non-empty; rd_ready: pop strobe
//   count       : FIFO occupancy
//   frame_err   : sticky, stop bit sampled low; overrun: sticky, byte dropped on a full FIFO
//   parity_err  : sticky parity mismatch (only with UART_RX_PARITY_EN)
//   clr_err     : clears the sticky flags; a same-cycle error event wins
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          clr_err
);

    localparam int DIV = baud_div(CLK_MHZ, BAUD);
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(DIV / 2 - 1);

    rx_state_t   state;
    logic [1:0]  sync;
    logic        rx_s, rx_d;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh;
    logic        push_q, full, empty, tick;
`ifdef UART_RX_PARITY_EN
    logic        par_bad;
`endif

    assign rx_s     = sync[1];
    assign tick     = cnt == '0;
    assign rd_valid = ~empty;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            sync      <= 2'b11;
            rx_d      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync   <= {sync[0], rx};
            rx_d   <= rx_s;
            push_q <= 1'b0;
            if (clr_err) frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            if (clr_err) parity_err <= 1'b0;
`endif
            if (state != IDLE && state != BREAK && !tick) cnt <= cnt - 1'b1;
            case (state)
                IDLE:
                    if (rx_d && !rx_s) begin
                        cnt   <= HALF;
                        state <= START;
                    end
                START:
                    if (tick) begin
                        cnt   <= RELOAD;
                        idx   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end
                DATA:
                    if (tick) begin
                        sh  <= {rx_s, sh[7:1]};
                        cnt <= RELOAD;
                        idx <= idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                        if (idx == 3'd7) state <= PARITY;
`else
                        if (idx == 3'd7) state <= STOP;
`endif
                    end
`ifdef UART_RX_PARITY_EN
                PARITY:
                    if (tick) begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        par_bad <= ^{sh, rx_s};
                        if (^{sh, rx_s}) parity_err <= 1'b1;
                        cnt   <= RELOAD;
                        state <= STOP;
                    end
`endif
                STOP:
                    if (tick) begin
                        if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                            push_q <= ~par_bad;
`else
                            push_q <= 1'b1;
`endif
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end
                BREAK:
                    if (rx_s) state <= IDLE;
                default:
                    state <= IDLE;
            endcase
        end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) overrun <= 1'b0;
        else overrun <= (overrun & ~clr_err) | (push_q & full & ~rd_ready);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_q),
        .din    (sh),
        .pop    (rd_ready),
        .dout   (rd_data),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

endmodule
